conv_engine_scheduler: RTL and testbench
========================================

Name: conv_engine_scheduler

Overview:
- Shares one convolution engine (feature stream in, feature stream out) among NUM_REQ requester streams.
- Grants the engine for one whole frame at a time:
  - LOAD forwards IN_IMAGES*IMAGE_HEIGHT*IMAGE_WIDTH input beats from the winner.
  - DRAIN routes OUT_IMAGES*IMAGE_HEIGHT*IMAGE_WIDTH result beats back to that requester.
  - The engine is then released.
- Sits between the layer-level stream fabric and a single convolution instance.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- IMAGE_HEIGHT, 28, rows per image.
- IMAGE_WIDTH, 28, columns per image.
- IN_IMAGES, 1, input images per frame (engine input_images).
- OUT_IMAGES, 20, output images per frame (engine output_images).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester input beat valid.
- req_ready  out  NUM_REQ  per-requester input beat accept.
- req_features  in  NUM_REQ x feature_type  per-requester input beat data.
- rsp_valid  out  NUM_REQ  per-requester result beat valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_features  out  feature_type  result data, broadcast to all requesters.
- eng_in_valid  out  1  to engine features_in.valid.
- eng_in_ready  in  1  from engine features_in.ready.
- eng_in_features  out  feature_type  to engine features_in.features[0].
- eng_out_valid  in  1  from engine features_out.valid.
- eng_out_ready  out  1  to engine features_out.ready.
- eng_out_features  in  feature_type  from engine features_out.features[0].
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- frames_done  out  16  count of completed frames; wraps at 16 bits.
- protocol_err  out  1  sticky; set when eng_out_valid is seen outside DRAIN.

Behaviour:
- Clock and reset: one clock, clock; reset_n is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - grant_id=0, rr_ptr=0, beat counters=0, frames_done=0, protocol_err=0.
  - All valid and ready outputs 0.
  - Reset mid-frame aborts the frame immediately; there is no partial drain.
- State IDLE:
  - Round-robin search starts at rr_ptr.
  - The first i with req_valid[i]=1 is registered into grant_id and the state moves to LOAD next cycle.
  - With no requests, the block stays in IDLE.
- State LOAD:
  - Combinational pass-through: eng_in_valid=req_valid[grant_id]; req_ready[grant_id]=eng_in_ready; eng_in_features=req_features[grant_id].
  - Every other req_ready is 0.
  - in_cnt increments on each eng_in_valid && eng_in_ready.
  - A handshake when in_cnt==IN_BEATS-1 moves the state to DRAIN and clears in_cnt.
- State DRAIN:
  - eng_in_valid=0 and every req_ready=0.
  - rsp_valid[grant_id]=eng_out_valid, all other rsp_valid=0.
  - eng_out_ready=rsp_ready[grant_id]; rsp_features=eng_out_features.
  - out_cnt increments on each handshake.
  - The handshake at OUT_BEATS-1 moves the state to RELEASE and clears out_cnt.
- State RELEASE, one cycle:
  - rr_ptr <= (grant_id+1) mod NUM_REQ.
  - frames_done increments.
  - Next state IDLE.
  - Back-to-back frames therefore have a 2-cycle gap: RELEASE plus the IDLE arbitration cycle.
- Outside DRAIN:
  - eng_out_ready=0 and all rsp_valid=0.
  - Any eng_out_valid=1 sets protocol_err; it is cleared only by reset.
- Beat counts: IN_BEATS=IN_IMAGES*IMAGE_HEIGHT*IMAGE_WIDTH and OUT_BEATS=OUT_IMAGES*IMAGE_HEIGHT*IMAGE_WIDTH. Counter width is $clog2(max)+1.
- Arbitration and stalls:
  - The grant is held for the full frame; requests arriving mid-frame wait.
  - A requester that drops req_valid mid-LOAD stalls the engine; there is no timeout.
- Outputs are combinational from registered state and counters, so latency is zero cycles through the block.
- rsp_features is valid only where rsp_valid is high.

Decomposition:
- Package (mnist_pkg):
  - feature_type is reused.
  - Add typedef sched_state_type {SCH_IDLE, SCH_LOAD, SCH_DRAIN, SCH_RELEASE}.
  - Add function rr_pick(valid vector, ptr) returning index and found flag.
- Sub-module: rr_arbiter (parameter NUM_REQ; inputs req vector and ptr; outputs grant index and any). It is purely combinational and reused by later pool and fc schedulers.

Test Plan:
- Config for all scenarios: NUM_REQ=2, IMAGE 4x4, IN_IMAGES=1, OUT_IMAGES=2, so IN_BEATS=16 and OUT_BEATS=32.
- Single requester: req0 sends 16 beats 1..16 and the engine model returns 32 beats 100..131.
  - eng_in sees 1..16 in order; rsp_valid[0] carries 100..131.
  - frames_done=1; busy falls 2 cycles after the last rsp handshake.
- Simultaneous requests: req0 and req1 are both valid at reset exit.
  - req0 is granted first and req1 next.
  - The third frame from req0 is granted only after req1's frame, proving rr_ptr rotation.
- Backpressure: eng_in_ready toggles every cycle and rsp_ready[0] is low for 5 cycles mid-drain.
  - No beat is lost or duplicated; the counts still reach exactly 16 and 32.
- Isolation: during req0's frame, req1_valid is held high.
  - req_ready[1]=0 and rsp_valid[1]=0 for the whole frame.
  - req1 is granted on the cycle after RELEASE+IDLE.
- Reset mid-frame: assert reset_n=0 at LOAD beat 7.
  - All outputs are 0 and frames_done=0.
  - A following full frame from req1 completes normally.
- Protocol error: the engine model asserts eng_out_valid during LOAD.
  - protocol_err=1 and stays 1 after frame completion until reset.

Source files
------------

// File: rtl/mnist_pkg.sv
// mnist_pkg: types and helpers shared by the mnist layer schedulers.
package mnist_pkg;
    typedef logic signed [15:0] feature_type;
    typedef enum logic [1:0] {SCH_IDLE, SCH_LOAD, SCH_DRAIN, SCH_RELEASE} sched_state_type;
    localparam int MAX_REQ = 16;
    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_type;
    // Scan n slots starting at ptr; the smallest offset from ptr wins.
    function automatic rr_pick_type rr_pick(input logic [MAX_REQ-1:0] valid, input logic [3:0] ptr, input int n);
        rr_pick_type r;
        logic [3:0] j;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            j = 4'((int'(ptr) + k) % n);
            if (k < n && valid[j]) begin
                r.found = 1'b1;
                r.idx = j;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/conv_engine_scheduler_if.sv
// conv_engine_scheduler_if: requester and engine stream signals around the scheduler.
interface conv_engine_scheduler_if import mnist_pkg::*; #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    feature_type        req_features [NUM_REQ];
    feature_type        rsp_features;
    logic               eng_in_valid, eng_in_ready, eng_out_valid, eng_out_ready;
    feature_type        eng_in_features, eng_out_features;
    modport master (
        output req_valid, req_features, rsp_ready, eng_in_ready, eng_out_valid, eng_out_features,
        input  req_ready, rsp_valid, rsp_features, eng_in_valid, eng_in_features, eng_out_ready
    );
    modport slave (
        input  req_valid, req_features, rsp_ready, eng_in_ready, eng_out_valid, eng_out_features,
        output req_ready, rsp_valid, rsp_features, eng_in_valid, eng_in_features, eng_out_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr.
module rr_arbiter import mnist_pkg::*; #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      grant,
    output logic               any
);
    rr_pick_type pick;
    assign pick = rr_pick(MAX_REQ'(req), 4'(ptr), NUM_REQ);
    assign grant = IW'(pick.idx);
    assign any = pick.found;
endmodule

// File: rtl/conv_engine_scheduler.sv
// conv_engine_scheduler: lends one convolution engine to NUM_REQ requesters, one whole frame at a time.
module conv_engine_scheduler import mnist_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int IMAGE_HEIGHT = 28,
    parameter int IMAGE_WIDTH = 28,
    parameter int IN_IMAGES = 1,
    parameter int OUT_IMAGES = 20,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    conv_engine_scheduler_if.slave  bus,
    output logic                    busy,
    output logic [IW-1:0]           grant_id,
    output logic [15:0]             frames_done,
    output logic                    protocol_err
);
    localparam int IN_BEATS = IN_IMAGES * IMAGE_HEIGHT * IMAGE_WIDTH;
    localparam int OUT_BEATS = OUT_IMAGES * IMAGE_HEIGHT * IMAGE_WIDTH;
    localparam int ICW = $clog2(IN_BEATS) + 1;
    localparam int OCW = $clog2(OUT_BEATS) + 1;
    sched_state_type    state, state_next;
    logic [IW-1:0]      rr_ptr, arb_grant;
    logic [ICW-1:0]     in_cnt;
    logic [OCW-1:0]     out_cnt;
    logic [NUM_REQ-1:0] sel;
    logic               arb_any, load, drain, in_hs, out_hs, in_last, out_last;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(bus.req_valid), .ptr(rr_ptr), .grant(arb_grant), .any(arb_any));
    always_comb begin
        load = state == SCH_LOAD;
        drain = state == SCH_DRAIN;
        sel = NUM_REQ'(1) << grant_id;
        bus.eng_in_valid = load && bus.req_valid[grant_id];
        bus.eng_in_features = load ? bus.req_features[grant_id] : '0;
        bus.req_ready = (load && bus.eng_in_ready) ? sel : '0;
        bus.rsp_valid = (drain && bus.eng_out_valid) ? sel : '0;
        bus.eng_out_ready = drain && bus.rsp_ready[grant_id];
        bus.rsp_features = drain ? bus.eng_out_features : '0;
        in_hs = bus.eng_in_valid && bus.eng_in_ready;
        out_hs = bus.eng_out_valid && bus.eng_out_ready;
        in_last = in_cnt == ICW'(IN_BEATS - 1);
        out_last = out_cnt == OCW'(OUT_BEATS - 1);
        busy = state != SCH_IDLE;
        state_next = state;
        unique case (state)
            SCH_IDLE:    state_next = arb_any ? SCH_LOAD : SCH_IDLE;
            SCH_LOAD:    state_next = (in_hs && in_last) ? SCH_DRAIN : SCH_LOAD;
            SCH_DRAIN:   state_next = (out_hs && out_last) ? SCH_RELEASE : SCH_DRAIN;
            SCH_RELEASE: state_next = SCH_IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCH_IDLE;
            grant_id <= '0;
            rr_ptr <= '0;
            in_cnt <= '0;
            out_cnt <= '0;
            frames_done <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == SCH_IDLE && arb_any) grant_id <= arb_grant;
            if (in_hs) in_cnt <= in_last ? '0 : in_cnt + ICW'(1);
            if (out_hs) out_cnt <= out_last ? '0 : out_cnt + OCW'(1);
            if (state == SCH_RELEASE) begin
                rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
                frames_done <= frames_done + 16'd1;
            end
            // Results arriving while nobody is draining would be silently lost.
            if (bus.eng_out_valid && !drain) protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_engine_scheduler.sv
// tb_conv_engine_scheduler: frame-level reference model with per-cycle checking and directed plus random scenarios.
module tb_conv_engine_scheduler;
    import mnist_pkg::*;
    localparam int NR = 2, IN_BEATS = 16, OUT_BEATS = 32;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        busy, protocol_err;
    logic [0:0]  grant_id;
    logic [15:0] frames_done;
    conv_engine_scheduler_if #(.NUM_REQ(NR)) bus ();
    conv_engine_scheduler #(.NUM_REQ(NR), .IMAGE_HEIGHT(4), .IMAGE_WIDTH(4), .IN_IMAGES(1), .OUT_IMAGES(2)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus.slave),
        .busy(busy), .grant_id(grant_id), .frames_done(frames_done), .protocol_err(protocol_err)
    );
    always #5 clock = ~clock;

    int checks = 0, errors = 0, cyc_n = 0;
    feature_type src_q [NR][$];
    feature_type eng_pend[$], eng_in_log[$], rsp_log[$];
    int eng_got, eng_frames, in_mode, rsp_hold, iso_viol, prev_busy, fall_cyc, last_rsp_cyc;
    bit req_rand, rsp_rand, bogus;
    // frame-level model: who owns the engine and how far the frame has progressed
    bit m_active, m_tail, m_perr;
    int m_gid, m_ptr, m_in, m_out, m_frames;
    int glog[$], rise_log[$], end_log[$];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc_n);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s got budget expired expected completion (cycle %0d)", name, cyc_n);
    endtask

    task automatic check_reset();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_frames", frames_done, 0);
        chk("rst_perr", protocol_err, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_eng_in_valid", bus.eng_in_valid, 0);
        chk("rst_eng_out_ready", bus.eng_out_ready, 0);
        chk("rst_eng_in_data", bus.eng_in_features, 0);
        chk("rst_rsp_data", bus.rsp_features, 0);
    endtask

    task automatic check_model();
        logic [NR-1:0] onehot;
        bit load, drain, in_hs, out_hs;
        int j;
        load = m_active && m_in < IN_BEATS;
        drain = m_active && m_in == IN_BEATS;
        onehot = NR'(1) << m_gid;
        chk("busy", busy, 32'(m_active || m_tail));
        chk("frames_done", frames_done, m_frames & 32'hffff);
        chk("grant_id", grant_id, m_gid);
        chk("req_ready", bus.req_ready, (load && bus.eng_in_ready) ? 32'(onehot) : 0);
        chk("eng_in_valid", bus.eng_in_valid, 32'(load && bus.req_valid[m_gid]));
        chk("rsp_valid", bus.rsp_valid, (drain && bus.eng_out_valid) ? 32'(onehot) : 0);
        chk("eng_out_ready", bus.eng_out_ready, 32'(drain && bus.rsp_ready[m_gid]));
        chk("protocol_err", protocol_err, 32'(m_perr));
        if (bus.eng_out_valid && !drain) m_perr = 1;
        in_hs = load && bus.req_valid[m_gid] && bus.eng_in_ready;
        out_hs = drain && bus.eng_out_valid && bus.rsp_ready[m_gid];
        if (in_hs) chk("eng_in_data", 32'(bus.eng_in_features), 32'(src_q[m_gid][0]));
        if (out_hs) begin
            chk("rsp_data", 32'(bus.rsp_features), 100 + 32 * m_frames + m_out);
            rsp_log.push_back(bus.rsp_features);
            last_rsp_cyc = cyc_n;
        end
        if (m_active && m_gid == 0 && (bus.req_ready[1] || bus.rsp_valid[1])) iso_viol++;
        for (int r = 0; r < NR; r++)
            if (bus.req_valid[r] && bus.req_ready[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
        if (bus.eng_in_valid && bus.eng_in_ready) begin
            eng_in_log.push_back(bus.eng_in_features);
            eng_got++;
            if (eng_got % IN_BEATS == 0) begin
                for (int k = 0; k < OUT_BEATS; k++) eng_pend.push_back(feature_type'(100 + 32 * eng_frames + k));
                eng_frames++;
            end
        end
        if (bus.eng_out_valid && bus.eng_out_ready && eng_pend.size() > 0) void'(eng_pend.pop_front());
        if (m_tail) begin
            m_tail = 0;
            m_frames++;
            m_ptr = (m_gid + 1) % NR;
        end else if (!m_active) begin
            if (bus.req_valid != 0) begin
                j = 0;
                for (int k = NR - 1; k >= 0; k--) if (bus.req_valid[(m_ptr + k) % NR]) j = (m_ptr + k) % NR;
                m_gid = j;
                m_active = 1;
                m_in = 0;
                m_out = 0;
                glog.push_back(j);
                rise_log.push_back(cyc_n + 1);
            end
        end else begin
            if (in_hs) m_in++;
            if (out_hs) m_out++;
            if (m_out == OUT_BEATS) begin
                m_active = 0;
                m_tail = 1;
                end_log.push_back(cyc_n);
            end
        end
        if (!busy && prev_busy != 0) fall_cyc = cyc_n;
        prev_busy = int'(busy);
    endtask

    task automatic drive();
        bus.eng_in_ready = (in_mode == 0) ? 1'b1 : (in_mode == 1) ? ~bus.eng_in_ready : 1'($urandom_range(0, 1));
        for (int r = 0; r < NR; r++) begin
            bus.req_valid[r] = src_q[r].size() > 0 && (!req_rand || $urandom_range(0, 3) != 0);
            bus.req_features[r] = src_q[r].size() > 0 ? src_q[r][0] : '0;
        end
        if (rsp_hold > 0) begin
            rsp_hold--;
            bus.rsp_ready = '0;
        end else bus.rsp_ready = rsp_rand ? NR'($urandom_range(0, 3)) : '1;
        bus.eng_out_valid = eng_pend.size() > 0 || bogus;
        bus.eng_out_features = eng_pend.size() > 0 ? eng_pend[0] : 16'h7eee;
    endtask

    task automatic cyc();
        @(negedge clock);
        cyc_n++;
        if (!reset_n) check_reset();
        else check_model();
        @(posedge clock);
        #1;
        drive();
    endtask

    task automatic clear_tb();
        for (int r = 0; r < NR; r++) src_q[r].delete();
        eng_in_log.delete();
        rsp_log.delete();
        glog.delete();
        rise_log.delete();
        end_log.delete();
        iso_viol = 0;
    endtask

    task automatic do_reset(int n);
        reset_n = 1'b0;
        {m_active, m_tail, m_perr, bogus} = '0;
        {m_gid, m_ptr, m_in, m_out, m_frames, prev_busy, rsp_hold, eng_got, eng_frames} = '0;
        eng_pend.delete();
        repeat (n) cyc();
        reset_n = 1'b1;
    endtask

    task automatic push_frame(int r, int base);
        for (int k = 1; k <= IN_BEATS; k++) src_q[r].push_back(feature_type'(base + k));
    endtask

    task automatic run_until_idle(string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && !m_active && !m_tail) break;
            cyc();
        end
        if (i == 3000) timeout(name);
        repeat (2) cyc();
    endtask

    initial begin
        int f0, e0, r0;
        {req_rand, rsp_rand} = '0;
        in_mode = 0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.eng_in_ready = 1'b0;
        bus.eng_out_valid = 1'b0;
        bus.eng_out_features = '0;
        for (int r = 0; r < NR; r++) bus.req_features[r] = '0;
        // single requester, no backpressure
        clear_tb();
        do_reset(3);
        push_frame(0, 0);
        run_until_idle("single");
        chk("single_in_count", eng_in_log.size(), 16);
        chk("single_rsp_count", rsp_log.size(), 32);
        for (int k = 0; k < 16 && k < eng_in_log.size(); k++) chk("single_in_seq", 32'(eng_in_log[k]), k + 1);
        for (int k = 0; k < 32 && k < rsp_log.size(); k++) chk("single_rsp_seq", 32'(rsp_log[k]), 100 + k);
        chk("single_frames", frames_done, 1);
        chk("single_busy_fall", fall_cyc - last_rsp_cyc, 2);
        // both requesters valid at reset exit; req0 has two frames queued
        clear_tb();
        push_frame(0, 200);
        push_frame(0, 216);
        push_frame(1, 300);
        do_reset(2);
        run_until_idle("rr");
        chk("rr_grants", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("rr_grant0", glog[0], 0);
            chk("rr_grant1", glog[1], 1);
            chk("rr_grant2", glog[2], 0);
            chk("iso_gap", rise_log[1] - end_log[0], 3);
        end
        chk("iso_viol", iso_viol, 0);
        chk("rr_frames", frames_done, 3);
        // backpressure: toggling eng_in_ready, 5-cycle rsp stall mid-drain
        clear_tb();
        in_mode = 1;
        f0 = m_frames;
        e0 = eng_got;
        push_frame(0, 400);
        for (int i = 0; i < 500 && !(m_active && m_in == IN_BEATS && m_out >= 10); i++) cyc();
        if (!(m_active && m_out >= 10)) timeout("bp_wait");
        rsp_hold = 5;
        r0 = rsp_log.size();
        run_until_idle("bp");
        chk("bp_in_beats", eng_got - e0, 16);
        chk("bp_rsp_beats", rsp_log.size() + (m_out >= 10 ? 10 : 0) - r0, 32);
        chk("bp_frames", frames_done, 32'(f0 + 1));
        // reset at LOAD beat 7, then a clean frame from req1
        clear_tb();
        in_mode = 2;
        push_frame(0, 500);
        for (int i = 0; i < 500 && !(m_active && m_in == 7); i++) cyc();
        if (!(m_active && m_in == 7)) timeout("mid_wait");
        clear_tb();
        do_reset(2);
        chk("mid_frames_zero", frames_done, 0);
        push_frame(1, 600);
        run_until_idle("mid");
        chk("mid_frames", frames_done, 1);
        chk("mid_grant", grant_id, 1);
        // engine raises eng_out_valid during LOAD
        clear_tb();
        in_mode = 0;
        push_frame(0, 700);
        for (int i = 0; i < 500 && !(m_active && m_in == 3); i++) cyc();
        if (!(m_active && m_in == 3)) timeout("perr_wait");
        bogus = 1;
        cyc();
        bogus = 0;
        run_until_idle("perr");
        chk("perr_sticky", protocol_err, 1);
        repeat (5) cyc();
        chk("perr_hold", protocol_err, 1);
        do_reset(1);
        cyc();
        chk("perr_cleared", protocol_err, 0);
        // random mix of frames, gaps and backpressure
        clear_tb();
        {req_rand, rsp_rand} = 2'b11;
        in_mode = 2;
        for (int n = 0; n < 6; n++) push_frame(int'($urandom_range(0, 1)), 1000 + 100 * n);
        run_until_idle("random");
        chk("random_frames", frames_done, 6);
        chk("random_perr", protocol_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
